// File: rtl/serial_slave_burst_pkg.sv
// Shared types and helpers for the serial bus slave.
// Frame layout: START | slave ID | rw | burst | address.
package serial_bus_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CFG,
        DECODE,
        RD_LOAD,
        RD_SHIFT,
        WR_SHIFT,
        WR_COMMIT
    } state_t;

    localparam logic [2:0] START    = 3'b111;
    localparam logic       RW_READ  = 1'b0;
    localparam logic       RW_WRITE = 1'b1;

    function automatic int cfg_len(input int slave_id_w,
                                   input int addr_width);
        return 3 + slave_id_w + 2 + addr_width;
    endfunction

endpackage

// File: rtl/serial_slave_burst_if.sv
// Serial interconnect bundle between bus master and one slave.
// Master drives control/data/valid/last; slave returns rD/ready/err.
interface serial_slave_burst_if;

    logic control;
    logic wD;
    logic valid;
    logic last;
    logic rD;
    logic ready;
    logic err;

    modport master (
        output control, wD, valid, last,
        input  rD, ready, err
    );

    modport slave (
        input  control, wD, valid, last,
        output rD, ready, err
    );

endinterface

// File: rtl/serial_slave_burst_ram.sv
// Single-port synchronous RAM, one-cycle read latency, no reset.
// Read data holds until the next read enable.
module slave_ram #(
    parameter int ADDR_DEPTH = 2048,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 11
) (
    input  logic                  clk,
    input  logic                  i_we,
    input  logic                  i_re,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    output logic [DATA_WIDTH-1:0] o_rdata
);

    logic [DATA_WIDTH-1:0] r_mem [ADDR_DEPTH];
    logic [DATA_WIDTH-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_addr] <= i_wdata;
        if (i_re) r_rdata <= r_mem[i_addr];
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/serial_slave_burst.sv
// Memory-backed serial bus slave with burst and address wrap.
// Define SERIAL_SLAVE_PARITY_EN for frame and read-word parity.
module serial_slave_burst
    import serial_bus_pkg::*;
#(
    parameter int ADDR_DEPTH = 2048,
    parameter int DATA_WIDTH = 32,
    parameter int SLAVES     = 4,
    parameter int SLAVE_ID_W = (SLAVES > 1) ? $clog2(SLAVES) : 1
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic [SLAVE_ID_W-1:0] slave_ID,
    serial_slave_burst_if.slave   bus
);

    localparam int ADDR_WIDTH = (ADDR_DEPTH > 1) ? $clog2(ADDR_DEPTH) : 1;
    localparam int CFG_LEN    = cfg_len(SLAVE_ID_W, ADDR_WIDTH);
`ifdef SERIAL_SLAVE_PARITY_EN
    localparam int PAR        = 1;
`else
    localparam int PAR        = 0;
`endif
    localparam int FRAME_LEN  = CFG_LEN + PAR;
    localparam int RD_BITS    = DATA_WIDTH + PAR;
    localparam int CNT_MAX    = (FRAME_LEN > RD_BITS) ? FRAME_LEN : RD_BITS;
    localparam int CNT_W      = $clog2(CNT_MAX) + 1;

    localparam logic [CNT_W-1:0]      C_FRAME_LAST = CNT_W'(FRAME_LEN - 1);
    localparam logic [CNT_W-1:0]      C_RD_LAST    = CNT_W'(RD_BITS - 1);
    localparam logic [CNT_W-1:0]      C_WR_LAST    = CNT_W'(DATA_WIDTH - 1);
    localparam logic [ADDR_WIDTH-1:0] C_ADDR_TOP   = ADDR_WIDTH'(ADDR_DEPTH - 1);
    localparam logic [ADDR_WIDTH:0]   C_DEPTH      = (ADDR_WIDTH + 1)'(ADDR_DEPTH);

    state_t                r_state;
    logic [FRAME_LEN-1:0]  r_cfg;
    logic [CNT_W-1:0]      r_cnt;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic                  r_burst;
    logic                  r_last;
    logic [DATA_WIDTH-1:0] r_wsh;

    logic [2:0]            w_start;
    logic [SLAVE_ID_W-1:0] w_id;
    logic                  w_rw;
    logic                  w_burst;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic                  w_hit;
    logic                  w_addr_bad;
    logic                  w_par_bad;
    logic                  w_go;
    logic [ADDR_WIDTH-1:0] w_addr_nxt;
    logic [DATA_WIDTH-1:0] w_rdata;
    logic [DATA_WIDTH-1:0] w_rsh;
    logic                  w_rbit;

    assign w_start    = r_cfg[FRAME_LEN-1 -: 3];
    assign w_id       = r_cfg[FRAME_LEN-4 -: SLAVE_ID_W];
    assign w_rw       = r_cfg[FRAME_LEN-4-SLAVE_ID_W];
    assign w_burst    = r_cfg[FRAME_LEN-5-SLAVE_ID_W];
    assign w_addr     = r_cfg[PAR +: ADDR_WIDTH];
    assign w_hit      = (w_start == START) && (w_id == slave_ID);
    assign w_addr_bad = {1'b0, w_addr} >= C_DEPTH;
`ifdef SERIAL_SLAVE_PARITY_EN
    assign w_par_bad  = ^r_cfg;
`else
    assign w_par_bad  = 1'b0;
`endif
    assign w_go       = !w_par_bad && w_hit && !w_addr_bad;
    assign w_addr_nxt = (r_addr == C_ADDR_TOP) ? '0 : r_addr + 1'b1;

    // Read word stays on the RAM output; select the bit by shifting
    assign w_rsh = w_rdata << r_cnt;
`ifdef SERIAL_SLAVE_PARITY_EN
    assign w_rbit = (r_cnt == C_RD_LAST) ? ^w_rdata : w_rsh[DATA_WIDTH-1];
`else
    assign w_rbit = w_rsh[DATA_WIDTH-1];
`endif

    assign bus.rD    = (r_state == RD_SHIFT) && w_rbit;
    assign bus.ready = (r_state == RD_SHIFT) || (r_state == WR_SHIFT);
    assign bus.err   = (r_state == DECODE) &&
                       (w_par_bad || (w_hit && w_addr_bad));

    slave_ram #(
        .ADDR_DEPTH (ADDR_DEPTH),
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clk     (clk),
        .i_we    (r_state == WR_COMMIT),
        .i_re    (r_state == RD_LOAD),
        .i_addr  (r_addr),
        .i_wdata (r_wsh),
        .o_rdata (w_rdata)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= IDLE;
            r_cfg   <= '0;
            r_cnt   <= '0;
            r_addr  <= '0;
            r_burst <= 1'b0;
            r_last  <= 1'b0;
            r_wsh   <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (bus.control) begin
                        r_cfg   <= FRAME_LEN'(1);
                        r_cnt   <= CNT_W'(1);
                        r_state <= CFG;
                    end
                end
                CFG: begin
                    r_cfg <= {r_cfg[FRAME_LEN-2:0], bus.control};
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == C_FRAME_LAST) begin
                        r_cnt   <= '0;
                        r_state <= DECODE;
                    end
                end
                DECODE: begin
                    r_cnt   <= '0;
                    r_last  <= 1'b0;
                    r_state <= IDLE;
                    if (w_go) begin
                        r_addr  <= w_addr;
                        r_burst <= w_burst;
                        r_state <= (w_rw == RW_WRITE) ? WR_SHIFT : RD_LOAD;
                    end
                end
                RD_LOAD: begin
                    r_cnt   <= '0;
                    r_state <= RD_SHIFT;
                end
                RD_SHIFT: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == C_RD_LAST) begin
                        r_cnt <= '0;
                        if (!r_burst || bus.last) begin
                            r_state <= IDLE;
                        end else begin
                            r_addr  <= w_addr_nxt;
                            r_state <= RD_LOAD;
                        end
                    end
                end
                WR_SHIFT: begin
                    if (bus.valid) begin
                        r_wsh <= {r_wsh[DATA_WIDTH-2:0], bus.wD};
                        r_cnt <= r_cnt + 1'b1;
                        if (r_cnt == C_WR_LAST) begin
                            r_cnt   <= '0;
                            r_last  <= bus.last;
                            r_state <= WR_COMMIT;
                        end
                    end
                end
                WR_COMMIT: begin
                    if (!r_burst || r_last) begin
                        r_state <= IDLE;
                    end else begin
                        r_addr  <= w_addr_nxt;
                        r_last  <= 1'b0;
                        r_state <= WR_SHIFT;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_slave_burst.sv
// Scoreboard bench for serial_slave_burst (8-bit words, 12-word RAM, ID 2).
// Define SERIAL_SLAVE_PARITY_EN to exercise the parity build.
module tb_serial_slave_burst;

    localparam int DW    = 8;
    localparam int DEPTH = 12;
    localparam int SL    = 4;
    localparam int SW    = 2;
    localparam int AW    = 4;
`ifdef SERIAL_SLAVE_PARITY_EN
    localparam int PAR   = 1;
`else
    localparam int PAR   = 0;
`endif
    localparam int CL    = 3 + SW + 2 + AW;
    localparam int FL    = CL + PAR;
    localparam int RB    = DW + PAR;

    logic          clk    = 1'b0;
    logic          resetn = 1'b0;
    logic [SW-1:0] sid    = 2'd2;

    serial_slave_burst_if bus ();

    serial_slave_burst #(
        .ADDR_DEPTH (DEPTH),
        .DATA_WIDTH (DW),
        .SLAVES     (SL)
    ) dut (
        .clk      (clk),
        .resetn   (resetn),
        .slave_ID (sid),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] model [DEPTH];
    bit            q_exp [$];
    int            n_vec;
    int            n_bad;
    int            n_errp;

    always @(negedge clk) if (bus.err === 1'b1) n_errp++;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [2:0] st, input logic [SW-1:0] id,
                              input logic rw, input logic bst,
                              input logic [AW-1:0] a, input bit bad_par);
        logic [CL-1:0] c;
        logic [FL-1:0] f;
        c = {st, id, rw, bst, a};
`ifdef SERIAL_SLAVE_PARITY_EN
        f = {c, (^c) ^ bad_par};
`else
        f = c;
        if (bad_par) f = c;
`endif
        for (int i = FL - 1; i >= 0; i--) begin
            bus.control = f[i];
            tick();
        end
        bus.control = 1'b0;
    endtask

    task automatic push_word(input logic [DW-1:0] w);
        for (int i = DW - 1; i >= 0; i--) q_exp.push_back(w[i]);
`ifdef SERIAL_SLAVE_PARITY_EN
        q_exp.push_back(^w);
`endif
    endtask

    task automatic test_reset;
        resetn = 1'b0;
        repeat (3) tick();
        n_vec++;
        if (bus.ready !== 1'b0 || bus.rD !== 1'b0 || bus.err !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_outputs: ready=%b rD=%b err=%b want 0 0 0",
                     bus.ready, bus.rD, bus.err);
        end
        resetn = 1'b1;
        tick();
    endtask

    task automatic test_read(input logic [AW-1:0] a, input int nw,
                             input bit bst, input string nm);
        int            cyc   = 0;
        int            got   = 0;
        int            first = -1;
        int            lastc = -1;
        int            total = nw * RB;
        int            ad    = int'(a);
        bit            e;
        for (int k = 0; k < nw; k++) begin
            push_word(model[ad]);
            ad = (ad == DEPTH - 1) ? 0 : ad + 1;
        end
        bus.last = 1'b0;
        send_frame(3'b111, 2'd2, 1'b0, bst, a, 1'b0);
        n_vec++;
        if (bus.err !== 1'b0 || bus.ready !== 1'b0) begin
            n_bad++;
            $display("FAIL %s_decode: err=%b ready=%b want 0 0",
                     nm, bus.err, bus.ready);
        end
        while (got < total && cyc < 200) begin
            tick();
            cyc++;
            if (bus.ready === 1'b1) begin
                if (first < 0) first = cyc;
                e = q_exp.pop_front();
                n_vec++;
                if (bus.rD !== e) begin
                    n_bad++;
                    $display("FAIL %s_bit%0d: rD=%b want %b", nm, got, bus.rD, e);
                end
                got++;
                lastc = cyc;
                if (got == total) bus.last = bst;
            end
        end
        n_vec++;
        if (got != total) begin
            n_bad++;
            $display("FAIL %s_timeout: bits=%0d want %0d", nm, got, total);
        end
        n_vec++;
        if (first != 2) begin
            n_bad++;
            $display("FAIL %s_latency: first ready at %0d want 2", nm, first);
        end
        n_vec++;
        if (lastc - first + 1 != total + nw - 1) begin
            n_bad++;
            $display("FAIL %s_span: %0d cycles want %0d",
                     nm, lastc - first + 1, total + nw - 1);
        end
        tick();
        bus.last = 1'b0;
        n_vec++;
        if (bus.ready !== 1'b0 || q_exp.size() != 0) begin
            n_bad++;
            $display("FAIL %s_end: ready=%b left=%0d want 0 0",
                     nm, bus.ready, q_exp.size());
        end
        q_exp.delete();
    endtask

    task automatic test_write(input logic [AW-1:0] a, input logic [DW-1:0] w0,
                              input logic [DW-1:0] w1, input int nw,
                              input bit bst, input int stall_bit,
                              input string nm);
        logic [DW-1:0] wd;
        int            wt;
        int            ad;
        send_frame(3'b111, 2'd2, 1'b1, bst, a, 1'b0);
        n_vec++;
        if (bus.err !== 1'b0) begin
            n_bad++;
            $display("FAIL %s_decode: err=%b want 0", nm, bus.err);
        end
        for (int k = 0; k < nw; k++) begin
            wd = (k == 0) ? w0 : w1;
            for (int i = DW - 1; i >= 0; i--) begin
                wt = 0;
                while (bus.ready !== 1'b1 && wt < 10) begin
                    tick();
                    wt++;
                end
                n_vec++;
                if (bus.ready !== 1'b1) begin
                    n_bad++;
                    $display("FAIL %s_ready_wait: ready=%b want 1", nm, bus.ready);
                end
                if (k == nw - 1 && i == stall_bit) begin
                    bus.valid = 1'b0;
                    for (int s = 0; s < 3; s++) begin
                        tick();
                        n_vec++;
                        if (bus.ready !== 1'b1) begin
                            n_bad++;
                            $display("FAIL %s_stall%0d: ready=%b want 1",
                                     nm, s, bus.ready);
                        end
                    end
                end
                bus.wD    = wd[i];
                bus.valid = 1'b1;
                bus.last  = (k == nw - 1 && i == 0) ? bst : 1'b0;
                tick();
                bus.valid = 1'b0;
                bus.last  = 1'b0;
            end
        end
        n_vec++;
        if (bus.ready !== 1'b0) begin
            n_bad++;
            $display("FAIL %s_commit: ready=%b want 0", nm, bus.ready);
        end
        tick();
        ad = int'(a);
        model[ad] = w0;
        if (nw > 1) model[(ad == DEPTH - 1) ? 0 : ad + 1] = w1;
    endtask

    task automatic test_burst_wrap;
        int e0;
        e0 = n_errp;
        test_write(4'd11, 8'h3C, 8'h81, 2, 1'b1, 4, "burst_wr");
        test_read(4'd11, 2, 1'b1, "burst_rd");
        test_read(4'd0, 1, 1'b0, "wrap_rd0");
        n_vec++;
        if (n_errp != e0) begin
            n_bad++;
            $display("FAIL burst_err: pulses=%0d want 0", n_errp - e0);
        end
    endtask

    task automatic test_bad_id;
        int e0;
        int rdy;
        e0  = n_errp;
        rdy = 0;
        send_frame(3'b111, 2'd1, 1'b0, 1'b0, 4'd3, 1'b0);
        for (int i = 0; i < 12; i++) begin
            if (bus.ready === 1'b1) rdy++;
            tick();
        end
        n_vec++;
        if (rdy != 0 || n_errp != e0) begin
            n_bad++;
            $display("FAIL bad_id: ready_cycles=%0d err_pulses=%0d want 0 0",
                     rdy, n_errp - e0);
        end
        test_read(4'd3, 1, 1'b0, "after_bad_id");
    endtask

    task automatic test_bad_addr;
        int e0;
        int rdy;
        e0  = n_errp;
        rdy = 0;
        send_frame(3'b111, 2'd2, 1'b0, 1'b0, 4'd13, 1'b0);
        n_vec++;
        if (bus.err !== 1'b1) begin
            n_bad++;
            $display("FAIL bad_addr_err: err=%b want 1", bus.err);
        end
        for (int i = 0; i < 8; i++) begin
            tick();
            if (bus.ready === 1'b1) rdy++;
        end
        n_vec++;
        if (rdy != 0 || n_errp != e0 + 1) begin
            n_bad++;
            $display("FAIL bad_addr_pulse: ready_cycles=%0d pulses=%0d want 0 1",
                     rdy, n_errp - e0);
        end
    endtask

    task automatic test_reset_abort;
        logic [DW-1:0] wd;
        int            wt;
        wd = 8'hFF;
        send_frame(3'b111, 2'd2, 1'b1, 1'b0, 4'd3, 1'b0);
        for (int i = DW - 1; i >= DW - 6; i--) begin
            wt = 0;
            while (bus.ready !== 1'b1 && wt < 10) begin
                tick();
                wt++;
            end
            bus.wD    = wd[i];
            bus.valid = 1'b1;
            if (i == DW - 6) begin
                #2 resetn = 1'b0;
                #1;
            end else begin
                tick();
            end
        end
        n_vec++;
        if (bus.ready !== 1'b0 || bus.rD !== 1'b0 || bus.err !== 1'b0) begin
            n_bad++;
            $display("FAIL abort_outputs: ready=%b rD=%b err=%b want 0 0 0",
                     bus.ready, bus.rD, bus.err);
        end
        bus.valid = 1'b0;
        tick();
        tick();
        resetn = 1'b1;
        tick();
        test_read(4'd3, 1, 1'b0, "after_abort");
    endtask

`ifdef SERIAL_SLAVE_PARITY_EN
    task automatic test_parity;
        int e0;
        e0 = n_errp;
        send_frame(3'b111, 2'd2, 1'b0, 1'b0, 4'd3, 1'b1);
        n_vec++;
        if (bus.err !== 1'b1) begin
            n_bad++;
            $display("FAIL parity_err: err=%b want 1", bus.err);
        end
        tick();
        tick();
        n_vec++;
        if (bus.ready !== 1'b0 || n_errp != e0 + 1) begin
            n_bad++;
            $display("FAIL parity_after: ready=%b pulses=%0d want 0 1",
                     bus.ready, n_errp - e0);
        end
        test_read(4'd3, 1, 1'b0, "parity_rd");
    endtask
`endif

    initial begin
        bus.control = 1'b0;
        bus.wD      = 1'b0;
        bus.valid   = 1'b0;
        bus.last    = 1'b0;
        n_vec       = 0;
        n_bad       = 0;
        n_errp      = 0;
        for (int i = 0; i < DEPTH; i++) model[i] = 'x;
        test_reset();
        test_write(4'd3, 8'hA5, 8'h00, 1, 1'b0, -1, "wr_a5");
        test_read(4'd3, 1, 1'b0, "rd_a5");
        test_burst_wrap();
        test_bad_id();
        test_bad_addr();
        test_reset_abort();
`ifdef SERIAL_SLAVE_PARITY_EN
        test_parity();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
